// File: rtl/gold_ring_router.sv
// Three-port ring router node (cw / ccw / PE) with two polarity-multiplexed VCs.
// Optional ROUTER_VC_CHECK_EN: ring inputs whose vc bit differs from polarity are acked and dropped.
module gold_ring_router #(
  parameter int PAC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  input  logic                 cwsi,
  input  logic                 ccwsi,
  input  logic                 pesi,
  output logic                 cwri,
  output logic                 ccwri,
  output logic                 peri,
  input  logic [PAC_WIDTH-1:0] cwdi,
  input  logic [PAC_WIDTH-1:0] ccwdi,
  input  logic [PAC_WIDTH-1:0] pedi,
  output logic                 cwso,
  output logic                 ccwso,
  output logic                 peso,
  input  logic                 cwro,
  input  logic                 ccwro,
  input  logic                 pero,
  output logic [PAC_WIDTH-1:0] cwdo,
  output logic [PAC_WIDTH-1:0] ccwdo,
  output logic [PAC_WIDTH-1:0] pedo
);

  localparam int NP = 3;
  localparam logic [1:0] CW = 2'd0, CCW = 2'd1, PE = 2'd2;

  logic [NP-1:0][1:0]                in_full, out_full, rr_ptr;
  logic [NP-1:0][1:0][PAC_WIDTH-1:0] in_data, out_data;
  logic [NP-1:0]                     si, ro, ri, so, cap;
  logic [NP-1:0]                     req_a, req_b, gnt_a, gnt_b, mv_in, mv_out;
  logic [NP-1:0][PAC_WIDTH-1:0]      di, dout, in_sel, mv_data, mv_src_data;
  logic [NP-1:0][7:0]                hop;
  logic [NP-1:0][1:0]                tgt;
  logic                              p, v;

  assign p  = polarity;
  assign v  = ~polarity;
  assign si = {pesi, ccwsi, cwsi};
  assign ro = {pero, ccwro, cwro};
  assign di = {pedi, ccwdi, cwdi};

  assign {peri, ccwri, cwri} = ri;
  assign {peso, ccwso, cwso} = so;
  assign cwdo  = dout[0];
  assign ccwdo = dout[1];
  assign pedo  = dout[2];

  generate
    for (genvar x = 0; x < NP; x++) begin : g_port
      // external side works on VC p
      assign ri[x]   = ~in_full[x][p];
      assign so[x]   = out_full[x][p];
      assign dout[x] = so[x] ? out_data[x][p] : '0;

      if (x == 2) begin : g_pe_cap
        assign cap[x] = si[x] & ri[x];
      end else begin : g_ring_cap
`ifdef ROUTER_VC_CHECK_EN
        assign cap[x] = si[x] & ri[x] & (di[x][PAC_WIDTH-1] == p);
`else
        assign cap[x] = si[x] & ri[x];
`endif
      end

      // internal side works on VC ~p; hop decrements with saturation, vc/dir untouched
      assign in_sel[x]  = in_data[x][v];
      assign hop[x]     = in_sel[x][55:48];
      assign mv_data[x] = {in_sel[x][PAC_WIDTH-1:56],
                           (hop[x] == 8'd0) ? 8'd0 : hop[x] - 8'd1,
                           in_sel[x][47:0]};

      if (x == 2) begin : g_pe_route
        assign tgt[x] = in_sel[x][PAC_WIDTH-2] ? CCW : CW;
      end else begin : g_ring_route
        assign tgt[x] = (hop[x] == 8'd0) ? PE : ((x == 0) ? CW : CCW);
      end
    end

    // Output o is contested by requester A (ring side, or cw for the PE port) and B.
    for (genvar o = 0; o < NP; o++) begin : g_arb
      localparam int RA = (o == 1) ? 1 : 0;
      localparam int RB = (o == 2) ? 1 : 2;
      localparam logic [1:0] OT = 2'(o);
      assign req_a[o] = in_full[RA][v] & (tgt[RA] == OT);
      assign req_b[o] = in_full[RB][v] & (tgt[RB] == OT);
      assign gnt_b[o] = ~out_full[o][v] & req_b[o] & (~req_a[o] | rr_ptr[o][v]);
      assign gnt_a[o] = ~out_full[o][v] & req_a[o] & ~gnt_b[o];
      assign mv_out[o] = gnt_a[o] | gnt_b[o];
      assign mv_src_data[o] = gnt_b[o] ? mv_data[RB] : mv_data[RA];
    end
  endgenerate

  // each input targets exactly one output, so at most one term is set
  assign mv_in[0] = gnt_a[0] | gnt_a[2];
  assign mv_in[1] = gnt_a[1] | gnt_b[2];
  assign mv_in[2] = gnt_b[0] | gnt_b[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_full  <= '0;
      out_full <= '0;
      rr_ptr   <= '0;
      in_data  <= '0;
      out_data <= '0;
    end else begin
      for (int x = 0; x < NP; x++) begin
        if (cap[x]) begin
          in_full[x][p] <= 1'b1;
          in_data[x][p] <= di[x];
        end
        if (mv_in[x]) in_full[x][v] <= 1'b0;
        if (mv_out[x]) begin
          out_full[x][v] <= 1'b1;
          out_data[x][v] <= mv_src_data[x];
          rr_ptr[x][v]   <= ~gnt_b[x];
        end
        if (so[x] & ro[x]) out_full[x][p] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gold_ring_router.sv
// Bench for gold_ring_router: directed latency/arbitration steps, then random traffic
// scored against per-flow FIFOs built from the routing rules.
module tb_gold_ring_router;

  logic        clk, reset, polarity;
  logic        cwsi, ccwsi, pesi, cwro, ccwro, pero;
  logic [63:0] cwdi, ccwdi, pedi;
  wire         cwri, ccwri, peri, cwso, ccwso, peso;
  wire  [63:0] cwdo, ccwdo, pedo;

  int checks = 0;
  int errors = 0;

  gold_ring_router #(.PAC_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
    .cwri(cwri), .ccwri(ccwri), .peri(peri),
    .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
    .cwso(cwso), .ccwso(ccwso), .peso(peso),
    .cwro(cwro), .ccwro(ccwro), .pero(pero),
    .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [2:0]  si_w = {pesi, ccwsi, cwsi};
  wire [2:0]  ri_w = {peri, ccwri, cwri};
  wire [2:0]  so_w = {peso, ccwso, cwso};
  wire [2:0]  ro_w = {pero, ccwro, cwro};
  wire [63:0] do_w [3];
  assign do_w[0] = cwdo;
  assign do_w[1] = ccwdo;
  assign do_w[2] = pedo;

  // reference model state: one FIFO per (source, VC, destination)
  logic [63:0] q [18][$];
  logic [2:0]  hold;
  logic [63:0] hd [3];
  int          id = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_p(input logic val);
    if (polarity !== val) next();
  endtask

  // {dst[1:0], packet}: hop 0 on a ring input ejects to PE, PE picks ring by dir
  function automatic logic [65:0] route(input int src, input logic [63:0] d);
    logic [7:0] h, nh;
    logic [1:0] dst;
    h   = d[55:48];
    nh  = (h == 8'd0) ? 8'd0 : h - 8'd1;
    if (src == 2) dst = d[62] ? 2'd1 : 2'd0;
    else          dst = (h == 8'd0) ? 2'd2 : 2'(src);
    return {dst, d[63:56], nh, d[47:0]};
  endfunction

  function automatic int qtotal();
    int n = 0;
    for (int k = 0; k < 18; k++) n += q[k].size();
    return n;
  endfunction

  task automatic mon();
    logic [65:0] r;
    int k, s;
    for (int x = 0; x < 3; x++) begin
      if (si_w[x] && ri_w[x]) begin
        hold[x] = 1'b0;
`ifdef ROUTER_VC_CHECK_EN
        if (x != 2 && hd[x][63] != polarity) continue;
`endif
        r = route(x, hd[x]);
        k = x * 6 + int'(polarity) * 3 + int'(r[65:64]);
        q[k].push_back(r[63:0]);
      end
    end
    for (int o = 0; o < 3; o++) begin
      if (so_w[o] && ro_w[o]) begin
        s = int'(do_w[o][47:40]);
        if (s > 2) chk("rnd_src", 64'(s), 64'd0);
        else begin
          k = s * 6 + int'(polarity) * 3 + o;
          chk("rnd_avail", 64'(q[k].size() != 0), 64'd1);
          if (q[k].size() != 0) chk("rnd_data", do_w[o], q[k].pop_front());
        end
      end
    end
  endtask

  task automatic rnd_cycle(input bit gen);
    for (int x = 0; x < 3; x++) begin
      if (gen && !hold[x] && $urandom_range(0, 2) == 0) begin
        hold[x] = 1'b1;
        hd[x] = {1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom_range(0, 3)),
                 8'(x), 40'(id)};
        id++;
      end
    end
    cwsi  = hold[0]; cwdi  = hold[0] ? hd[0] : '0;
    ccwsi = hold[1]; ccwdi = hold[1] ? hd[1] : '0;
    pesi  = hold[2]; pedi  = hold[2] ? hd[2] : '0;
    cwro  = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    ccwro = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    pero  = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    smp();
    mon();
    next();
  endtask

  initial begin
    reset = 1'b0; polarity = 1'b0;
    cwsi = 0; ccwsi = 0; pesi = 0;
    cwdi = '0; ccwdi = '0; pedi = '0;
    cwro = 1; ccwro = 1; pero = 1;
    hold = '0;

    // reset state
    repeat (3) next();
    smp();
    chk("rst_so", 64'(so_w), 64'd0);
    chk("rst_ri", 64'(ri_w), 64'h7);
    chk("rst_cwdo", cwdo, 64'd0);
    chk("rst_ccwdo", ccwdo, 64'd0);
    chk("rst_pedo", pedo, 64'd0);
    next(); reset = 1'b1;
    repeat (3) begin
      next(); smp();
      chk("idle_so", 64'(so_w), 64'd0);
      chk("idle_do", cwdo | ccwdo | pedo, 64'd0);
    end

    // cw hop 1 passes through on cw
    next(); wait_p(1'b0);
    cwdi = 64'h0001_0000_0000_1234; cwsi = 1;
    smp(); chk("t2_ri", 64'(cwri), 64'd1);
    next(); cwsi = 0; cwdi = '0;
    smp(); chk("t2_early", 64'(cwso), 64'd0);
    next(); smp();
    chk("t2_so", 64'(cwso), 64'd1);
    chk("t2_do", cwdo, 64'h0000_0000_0000_1234);
    chk("t2_peso", 64'(peso), 64'd0);
    next(); next(); smp();
    chk("t2_gone", 64'(cwso), 64'd0);

    // cw hop 0 ejects to PE
    next(); wait_p(1'b0);
    cwdi = 64'h0000_0000_0000_00AB; cwsi = 1;
    next(); cwsi = 0; cwdi = '0;
    next(); smp();
    chk("t3_peso", 64'(peso), 64'd1);
    chk("t3_pedo", pedo, 64'h0000_0000_0000_00AB);
    chk("t3_ccwso", 64'(ccwso), 64'd0);

    // PE dir 1 injects on ccw, vc bit kept
    next(); next(); wait_p(1'b1);
    pedi = 64'h4003_0000_0000_0055; pesi = 1;
    next(); pesi = 0; pedi = '0;
    next(); smp();
    chk("t4_ccwso", 64'(ccwso), 64'd1);
    chk("t4_ccwdo", ccwdo, 64'h4002_0000_0000_0055);

    // backpressure: output held, input fills, order kept
    next(); next(); wait_p(1'b0);
    cwro = 0;
    cwdi = 64'h0001_0000_0000_0A01; cwsi = 1;
    next(); cwsi = 0; cwdi = '0;
    next();
    cwdi = 64'h0001_0000_0000_0B02; cwsi = 1;
    smp();
    chk("t5_ri_b", 64'(cwri), 64'd1);
    chk("t5_do_a", cwdo, 64'h0000_0000_0000_0A01);
    next(); cwsi = 0; cwdi = '0;
    next(); smp();
    chk("t5_ri_full", 64'(cwri), 64'd0);
    chk("t5_so_hold", 64'(cwso), 64'd1);
    chk("t5_do_hold", cwdo, 64'h0000_0000_0000_0A01);
    next(); next(); smp();
    chk("t5_do_hold2", cwdo, 64'h0000_0000_0000_0A01);
    cwro = 1;
    next(); next(); smp();
    chk("t5_so_b", 64'(cwso), 64'd1);
    chk("t5_do_b", cwdo, 64'h0000_0000_0000_0B02);
    chk("t5_ri_free", 64'(cwri), 64'd1);

    // mid-operation reset drops in-flight packet and clears arbitration pointers
    next(); next(); wait_p(1'b0);
    cwdi = 64'h0001_0000_0000_0777; cwsi = 1;
    next(); cwsi = 0; cwdi = '0;
    next(); smp();
    chk("mr_so", 64'(cwso), 64'd1);
    reset = 1'b0;
    #1;
    chk("mr_so_clr", 64'(cwso), 64'd0);
    next(); next(); reset = 1'b1;
    next(); smp(); chk("mr_after0", 64'(so_w), 64'd0);
    next(); smp(); chk("mr_after1", 64'(so_w), 64'd0);

    // cw-out contention: ring first, then PE over a newer ring packet
    next(); wait_p(1'b0);
    cwdi = 64'h0002_0000_0000_0C0C; cwsi = 1;
    pedi = 64'h0005_0000_0000_0D0D; pesi = 1;
    next(); cwsi = 0; pesi = 0; cwdi = '0; pedi = '0;
    next();
    cwdi = 64'h0002_0000_0000_0E0E; cwsi = 1;
    smp(); chk("t6_first", cwdo, 64'h0001_0000_0000_0C0C);
    next(); cwsi = 0; cwdi = '0;
    next(); smp(); chk("t6_second", cwdo, 64'h0004_0000_0000_0D0D);
    next(); next(); smp(); chk("t6_third", cwdo, 64'h0001_0000_0000_0E0E);

    // vc bit opposite to polarity on a ring input
    next(); next(); wait_p(1'b0);
    cwdi = 64'h8001_0000_0000_0F0F; cwsi = 1;
    smp(); chk("vc_ri", 64'(cwri), 64'd1);
    next(); cwsi = 0; cwdi = '0;
    next(); smp();
`ifdef ROUTER_VC_CHECK_EN
    chk("vc_drop", 64'(cwso), 64'd0);
`else
    chk("vc_keep_so", 64'(cwso), 64'd1);
    chk("vc_keep_do", cwdo, 64'h8000_0000_0000_0F0F);
`endif
    next(); next();

    // random traffic with random backpressure, then drain
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 400 && (hold != 0 || qtotal() != 0); c++) rnd_cycle(1'b0);
    chk("drain_left", 64'(qtotal()), 64'd0);
    chk("drain_hold", 64'(hold), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
